// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of an incoming square-wave tone and
// identifies which note of the C3..C4 scale it is. A note is reported only
// after MATCH_CNT consecutive in-tolerance periods. It is dropped when a
// period does not match or when the input goes silent for TIMEOUT cycles.
module tone_decoder #(
  parameter int TOL_SHIFT = 6,
  parameter int MATCH_CNT = 3,
  parameter int TIMEOUT   = 800000,
  // Nominal periods in clk cycles. Note i sits at bits [i*20 +: 20]
  // (index 0 = C3 in the low bits).
  parameter logic [159:0] NOM_TABLE = {20'd191110, 20'd202478, 20'd227273, 20'd255102,
                                       20'd286352, 20'd303380, 20'd340530, 20'd382234}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic        note_valid,
  output logic [2:0]  note_idx,
  output logic        note_change,
  output logic [19:0] period
);

  localparam int RUN_W = $clog2(MATCH_CNT + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               rise;
  logic [19:0]        cnt;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_next;
  logic [2:0]         cand;
  logic               hit;
  logic [2:0]         hit_idx;
  logic               timeout;

  // |p - nom| <= nom >> TOL_SHIFT, evaluated with a signed difference
  function automatic logic in_tol(input logic [19:0] p, input logic [19:0] nom);
    logic signed [20:0] diff;
    logic        [19:0] mag;
    diff = $signed({1'b0, p}) - $signed({1'b0, nom});
    mag  = diff[20] ? 20'(-diff) : diff[19:0];
    return (mag <= (nom >> TOL_SHIFT));
  endfunction

  // Three-flop chain: s1/s2 resolve metastability, s2 & ~s3 marks a rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign timeout = (cnt == 20'(TIMEOUT));

  // Period counter: reloads to 1 on each edge so that its value just before
  // the reload equals the edge-to-edge distance; saturates during silence
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= 20'd1;
    end else if (cnt != '1) begin
      cnt <= cnt + 20'd1;
    end
  end

  // Note lookup on the live counter value; tolerance bands never overlap,
  // so at most one entry can hit
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (in_tol(cnt, NOM_TABLE[i*20 +: 20])) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // Run length after this edge: extend a streak on the same candidate, else restart
  always_comb begin
    run_next = RUN_W'(1);
    if ((hit_idx == cand) && (run != '0)) begin
      run_next = run + 1'b1;
    end
  end

  // Lock state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run         <= '0;
      cand        <= '0;
      note_valid  <= 1'b0;
      note_idx    <= '0;
      note_change <= 1'b0;
      period      <= '0;
    end else begin
      note_change <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            run   <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period <= cnt;
            if (hit) begin
              cand <= hit_idx;
              run  <= run_next;
              if (run_next == RUN_W'(MATCH_CNT)) begin
                state       <= LOCKED;
                note_valid  <= 1'b1;
                note_idx    <= hit_idx;
                note_change <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end else if (timeout) begin
            state <= IDLE;
            run   <= '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period <= cnt;
            if (hit && (hit_idx != note_idx)) begin
              state      <= MEASURE;
              cand       <= hit_idx;
              run        <= RUN_W'(1);
              note_valid <= 1'b0;
            end else if (!hit) begin
              state      <= MEASURE;
              run        <= '0;
              note_valid <= 1'b0;
            end
          end else if (timeout) begin
            state      <= IDLE;
            run        <= '0;
            note_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder. The nominal table is scaled by 1/200
// (rounded) and TIMEOUT is shortened to 4000 so that the whole run stays
// short. Tolerance bands with TOL_SHIFT=6:
//   C3 1911+-29, D3 1703+-26, E3 1517+-23, F3 1432+-22,
//   G3 1276+-19, A3 1136+-17, B3 1012+-15, C4 956+-14
module tb_tone_decoder;

  logic        clk;
  logic        rst;
  logic        tone_in;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic        note_change;
  logic [19:0] period;

  int checks   = 0;
  int failures = 0;
  int chg_cnt  = 0;
  int vld_cnt  = 0;
  int chg_ref;
  int vld_ref;

  tone_decoder #(
    .TOL_SHIFT (6),
    .MATCH_CNT (3),
    .TIMEOUT   (4000),
    .NOM_TABLE ({20'd956, 20'd1012, 20'd1136, 20'd1276,
                 20'd1432, 20'd1517, 20'd1703, 20'd1911})
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note_valid  (note_valid),
    .note_idx    (note_idx),
    .note_change (note_change),
    .period      (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count note_change pulses and note_valid-high cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (note_change) chg_cnt++;
    if (note_valid)  vld_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n periods of p cycles each, starting with a rising edge, ending low
  task automatic wave(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tone_in = 1'b1;
      cycles(p / 2);
      tone_in = 1'b0;
      cycles(p - p / 2);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    tone_in = 1'b0;
    @(negedge clk);
    // Reset held three cycles with the input toggling
    for (int k = 0; k < 3; k++) begin
      tone_in = ~tone_in;
      cycles(1);
    end
    chk("rst_valid",  32'(note_valid),  32'd0);
    chk("rst_idx",    32'(note_idx),    32'd0);
    chk("rst_change", 32'(note_change), 32'd0);
    chk("rst_period", 32'(period),      32'd0);
    rst     = 1'b0;
    tone_in = 1'b0;
    vld_ref = vld_cnt;
    cycles(5000);
    chk("silent_valid",   32'(note_valid),        32'd0);
    chk("silent_vld_cyc", 32'(vld_cnt - vld_ref), 32'd0);

    // Lock C3: edges 1..3 not enough, 4th edge locks
    chg_ref = chg_cnt;
    wave(1911, 3);
    chk("c3_prelock_valid", 32'(note_valid), 32'd0);
    wave(1911, 2);
    chk("c3_valid",  32'(note_valid),        32'd1);
    chk("c3_idx",    32'(note_idx),          32'd0);
    chk("c3_period", 32'(period),            32'd1911);
    chk("c3_pulses", 32'(chg_cnt - chg_ref), 32'd1);

    // Switch to A3: first edge closing an A3 period drops, 2 more relock
    chg_ref = chg_cnt;
    wave(1136, 2);
    chk("a3_drop_valid", 32'(note_valid), 32'd0);
    chk("a3_drop_idx",   32'(note_idx),   32'd0);
    chk("a3_period",     32'(period),     32'd1136);
    wave(1136, 2);
    chk("a3_valid",  32'(note_valid),        32'd1);
    chk("a3_idx",    32'(note_idx),          32'd5);
    chk("a3_pulses", 32'(chg_cnt - chg_ref), 32'd1);

    // Off-tune period between B3 and A3 bands never locks
    wave(1050, 2);
    vld_ref = vld_cnt;
    wave(1050, 5);
    chk("off_valid",   32'(note_valid),        32'd0);
    chk("off_vld_cyc", 32'(vld_cnt - vld_ref), 32'd0);
    chk("off_period",  32'(period),            32'd1050);

    // Upper tolerance edge of C3 (1911+29) locks and pulses again
    chg_ref = chg_cnt;
    wave(1940, 4);
    chk("tol_in_valid",  32'(note_valid),        32'd1);
    chk("tol_in_idx",    32'(note_idx),          32'd0);
    chk("tol_in_period", 32'(period),            32'd1940);
    chk("tol_in_pulses", 32'(chg_cnt - chg_ref), 32'd1);

    // One cycle beyond the band (1911+30) never locks
    wave(1941, 2);
    vld_ref = vld_cnt;
    wave(1941, 5);
    chk("tol_out_valid",   32'(note_valid),        32'd0);
    chk("tol_out_vld_cyc", 32'(vld_cnt - vld_ref), 32'd0);
    chk("tol_out_period",  32'(period),            32'd1941);

    // G3 lock, then silence: drop about 4000 cycles after the last edge
    wave(1276, 5);
    chk("g3_valid", 32'(note_valid), 32'd1);
    chk("g3_idx",   32'(note_idx),   32'd4);
    cycles(2674);
    chk("g3_hold_valid", 32'(note_valid), 32'd1);
    cycles(100);
    chk("g3_silence_valid",  32'(note_valid), 32'd0);
    chk("g3_silence_period", 32'(period),     32'd1276);
    chk("g3_silence_idx",    32'(note_idx),   32'd4);

    // B3 lock from idle, then a one-cycle reset
    chg_ref = chg_cnt;
    wave(1012, 3);
    chk("b3_idle_prelock", 32'(note_valid), 32'd0);
    wave(1012, 1);
    chk("b3_valid", 32'(note_valid), 32'd1);
    chk("b3_idx",   32'(note_idx),   32'd6);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("mid_rst_valid",  32'(note_valid), 32'd0);
    chk("mid_rst_period", 32'(period),     32'd0);
    chk("mid_rst_idx",    32'(note_idx),   32'd0);
    chg_ref = chg_cnt;
    wave(1012, 3);
    chk("b3_relock_pre", 32'(note_valid), 32'd0);
    wave(1012, 1);
    chk("b3_relock_valid",  32'(note_valid),        32'd1);
    chk("b3_relock_idx",    32'(note_idx),          32'd6);
    chk("b3_relock_pulses", 32'(chg_cnt - chg_ref), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
